la_rle_capture: RTL

- Parametrised successor of the 24-channel logic-analyzer trace block: run-length-encodes up to CH_WIDTH user-project signals into 32-bit trace words, buffers them in an internal FIFO and streams them out on an AXI-Stream master.
- Adds over the previous generation: a mask/value start trigger, an explicit capture state machine, generic channel/depth widths, and a single clock domain for capture, FIFO and stream.
- Sits between the user-project probe bus and the AXIS switch; configuration comes from the LA register block.

---
 rtl/la_pkg.sv | 25 ++
 rtl/la_sync_fifo.sv | 78 +++++++
 rtl/la_rle_capture.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg
// Shared definitions for the run-length-encoding logic-analyzer capture block:
// trace word width, the null (resync) word, the capture FSM state encoding and
// a helper deriving the run-count field width from the channel count.
// -----------------------------------------------------------------------------
package la_pkg;

    localparam int               PKT_W    = 32;
    localparam logic [PKT_W-1:0] NULL_PKT = 32'h0;

    // Encodings are visible on la_state, so keep them fixed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        BLOCKED = 2'd3
    } la_state_e;

    // Run-count field fills whatever the channel field leaves of a trace word.
    function automatic int rc_width(input int ch_width);
        return PKT_W - ch_width;
    endfunction

endpackage

// File: rtl/la_sync_fifo.sv
// -----------------------------------------------------------------------------
// la_sync_fifo
// Single-clock first-word-fall-through FIFO with an occupancy output.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : synchronous flush (pointers and level to zero)
//   push_i      : write wdata_i; ignored while full (no bypass, even on pop)
//   wdata_i     : write data
//   pop_i       : consume the head word; ignored while empty
//   rdata_o     : head word, valid whenever valid_o is high
//   valid_o     : FIFO non-empty
//   full_o      : level == DEPTH
//   level_o     : number of stored words (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module la_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign valid_o = (level_q != '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;

    // NOTE: the storage array has no reset; only pointers and level do, and a
    // word is never read before it has been written, so resetting it would
    // just turn the RAM into thousands of resettable flops.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values and simulation order cannot change results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/la_rle_capture.sv
// -----------------------------------------------------------------------------
// la_rle_capture
// Run-length-encoding logic-analyzer capture. After a mask/value trigger the
// probed channels are compressed into 32-bit words {run_count, data}; a word is
// emitted whenever a masked channel changes or the run count saturates. Words
// are buffered in an FWFT FIFO and streamed out on an AXI-Stream master.
// On overflow the capture enters BLOCKED, discarding words until the FIFO has
// drained below cfg_l_thresh, then emits a NULL_PKT (rc = 0) to mark the gap.
//
// Ports:
//   axi_clk, axi_reset_n      clock, asynchronous active-low reset
//   cfg_enable                0 = synchronously clear FSM, FIFO, tx count
//   cfg_chan_mask             channels used for change detection and words
//   cfg_trig_mask/value       start trigger (mask 0 = immediate)
//   cfg_h_thresh/l_thresh     la_hpri_req set / clear (and BLOCKED resume) levels
//   cfg_pkt_len               beats per AXIS packet (0 treated as 1)
//   up_la_data                probed signals
//   m_tdata/tvalid/tready/tlast/tuser  AXI-Stream master
//   la_hpri_req               high-priority drain request
//   la_state                  current FSM state
//   drop_cnt                  saturating count of discarded words
//
// Build option: define LA_DROP_CNT_EN to implement drop_cnt; otherwise it is
// tied to zero and the counter is removed.
// -----------------------------------------------------------------------------
module la_rle_capture
    import la_pkg::*;
#(
    parameter int CH_WIDTH   = 24,
    parameter int FIFO_DEPTH = 64,
    parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset_n,
    input  logic                 cfg_enable,
    input  logic [CH_WIDTH-1:0]  cfg_chan_mask,
    input  logic [CH_WIDTH-1:0]  cfg_trig_mask,
    input  logic [CH_WIDTH-1:0]  cfg_trig_value,
    input  logic [LVL_WIDTH-1:0] cfg_h_thresh,
    input  logic [LVL_WIDTH-1:0] cfg_l_thresh,
    input  logic [7:0]           cfg_pkt_len,
    input  logic [CH_WIDTH-1:0]  up_la_data,
    output logic [PKT_W-1:0]     m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [1:0]           m_tuser,
    output logic                 la_hpri_req,
    output logic [1:0]           la_state,
    output logic [15:0]          drop_cnt
);

    localparam int                  RC_WIDTH = rc_width(CH_WIDTH);
    localparam logic [RC_WIDTH-1:0] RC_ONE   = RC_WIDTH'(1);

    la_state_e             state_q, state_d;
    logic [CH_WIDTH-1:0]   r_data_q, r_data_d;
    logic [RC_WIDTH-1:0]   rc_q, rc_d;
    logic [7:0]            tx_cnt_q, tx_cnt_d;
    logic                  hpri_q, hpri_d;

    logic                  push, drop;
    logic [PKT_W-1:0]      push_data;
    logic                  run_end, trig_hit;
    logic [PKT_W-1:0]      fifo_rdata;
    logic                  fifo_valid, fifo_full, fifo_pop;
    logic [LVL_WIDTH-1:0]  fifo_level;
    logic [7:0]            eff_len;
    logic                  tx_last;

    // A run ends on any masked channel change or when rc can count no further.
    assign run_end  = (|(cfg_chan_mask & (up_la_data ^ r_data_q))) | (&rc_q);
    assign trig_hit = (((up_la_data ^ cfg_trig_value) & cfg_trig_mask) == '0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        r_data_d  = r_data_q;
        rc_d      = rc_q;
        push      = 1'b0;
        drop      = 1'b0;
        push_data = {rc_q, r_data_q & cfg_chan_mask};

        if (!cfg_enable) begin
            state_d  = IDLE;
            r_data_d = '0;
            rc_d     = RC_ONE;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (trig_hit) begin
                        r_data_d = up_la_data;
                        rc_d     = RC_ONE;
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (run_end) begin
                        r_data_d = up_la_data;
                        rc_d     = RC_ONE;
                        // Fullness is judged on the stored level only; a pop in
                        // the same cycle does not rescue the word.
                        if (fifo_full) begin
                            drop    = 1'b1;
                            state_d = BLOCKED;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        rc_d = rc_q + RC_ONE;
                    end
                end
                BLOCKED: begin
                    if (fifo_level < cfg_l_thresh) begin
                        push      = 1'b1;
                        push_data = NULL_PKT;
                        r_data_d  = up_la_data;
                        rc_d      = RC_ONE;
                        state_d   = CAPTURE;
                    end else if (run_end) begin
                        // Runs keep being tracked so the words lost are counted.
                        drop     = 1'b1;
                        r_data_d = up_la_data;
                        rc_d     = RC_ONE;
                    end else begin
                        rc_d = rc_q + RC_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Drain request with hysteresis; clear takes precedence over set.
    always_comb begin
        hpri_d = hpri_q;
        if (!cfg_enable || (fifo_level < cfg_l_thresh)) begin
            hpri_d = 1'b0;
        end else if (fifo_level >= cfg_h_thresh) begin
            hpri_d = 1'b1;
        end
    end

    assign eff_len  = (cfg_pkt_len == 8'd0) ? 8'd1 : cfg_pkt_len;
    assign tx_last  = (tx_cnt_q == eff_len);
    assign fifo_pop = fifo_valid & m_tready;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (!cfg_enable) begin
            tx_cnt_d = 8'd1;
        end else if (fifo_pop) begin
            tx_cnt_d = tx_last ? 8'd1 : tx_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q  <= IDLE;
            r_data_q <= '0;
            rc_q     <= RC_ONE;
            tx_cnt_q <= 8'd1;
            hpri_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_data_q <= r_data_d;
            rc_q     <= rc_d;
            tx_cnt_q <= tx_cnt_d;
            hpri_q   <= hpri_d;
        end
    end

    la_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axi_clk),
        .rst_n   (axi_reset_n),
        .clear_i (~cfg_enable),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

`ifdef LA_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            drop_cnt_q <= 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_cnt    = 16'd0;
`endif

    // Data is forced to zero while empty so the bus idles at a known value.
    assign m_tdata     = fifo_valid ? fifo_rdata : '0;
    assign m_tvalid    = fifo_valid;
    assign m_tlast     = fifo_valid & tx_last;
    assign m_tuser     = 2'b00;
    assign la_hpri_req = hpri_q;
    assign la_state    = state_q;

endmodule
